control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Hardwired Moore control sequencer for the Mini SRC datapath; sits directly upstream of `datapath` and drives every datapath control strobe.
- Fetches each instruction and decodes `ir[31:27]`, then steps one state per clock through the fixed T-step sequence for that opcode.
- Loops back to fetch when the sequence ends. Halts on `halt` until reset.

Parameters:
- IR_WIDTH, 32, instruction register width; opcode is `ir[IR_WIDTH-1 -: 5]`.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, all state changes on the rising edge
- clr  in  1  synchronous active-high reset
- ir  in  IR_WIDTH  instruction register contents from datapath
- con_out  in  1  branch condition result from datapath CON FF
- pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out, ba_out  out  1 each  bus-drive selects
- mar_enable, z_enable, pc_enable, mdr_enable, ir_enable, y_enable, lo_enable, hi_enable, r15_enable, outport_enable, inport_enable, con_enable  out  1 each  register load enables (inport_enable held 0)
- read, ram_write, pc_increment  out  1 each  memory read, memory write, ALU PC+1 select
- gra, grb, grc, r_in, r_out  out  1 each  register-select and register file in/out strobes
- run  out  1  1 while executing, 0 in HALT
- instr_done  out  1  one-cycle pulse in the last T-step of each instruction
- instr_count  out  CNT_WIDTH  retired instructions, saturating

Behaviour:
- One clock, `clk`. `clr` is synchronous and active-high: on any rising edge with `clr`=1, state←T0, `instr_count`←0, `run`←1.
- While `clr`=1, all strobes are forced to 0 combinationally. This also applies to a reset issued mid-instruction; no partial write may follow reset.
- Strobes are decoded from the state register. The only exception is `pc_enable` in BR3, which equals `con_out`.
- Fetch: T0 = `pc_out` `mar_enable` `pc_increment` `z_enable`; T1 = `zlo_out` `pc_enable` `read` `mdr_enable`; T2 = `mdr_out` `ir_enable`. The opcode is sampled at the T2→T3 edge using the IR value loaded during T2.
- ld (00000): T3 `grb` `ba_out` `y_enable`; T4 `c_sign_extended_out` `z_enable`; T5 `zlo_out` `mar_enable`; T6 `read` `mdr_enable`; T7 `mdr_out` `gra` `r_in`.
- ldi (00001): T3 and T4 as ld; T5 `zlo_out` `gra` `r_in`.
- st (00010): T3–T5 as ld; T6 `gra` `r_out` `mdr_enable`; T7 `ram_write`.
- Register ALU (00011–01011): T3 `grb` `r_out` `y_enable`; T4 `grc` `r_out` `z_enable`; T5 `zlo_out` `gra` `r_in`.
- Immediate ALU (01100–01110): T3 `grb` `r_out` `y_enable`; T4 `c_sign_extended_out` `z_enable`; T5 `zlo_out` `gra` `r_in`.
- mul/div (01111, 10000): T3 `gra` `r_out` `y_enable`; T4 `grb` `r_out` `z_enable`; T5 `zlo_out` `lo_enable`; T6 `zhi_out` `hi_enable`.
- neg/not (10001, 10010): T3 `grb` `r_out` `z_enable`; T4 `zlo_out` `gra` `r_in`.
- Branch (10011): BR0 `gra` `r_out` `con_enable`; BR1 `pc_out` `y_enable`; BR2 `c_sign_extended_out` `z_enable`; BR3 `zlo_out`, `pc_enable`=`con_out`.
- jr (10100): T3 `gra` `r_out` `pc_enable`.
- jal (10101): T3 `pc_out` `r15_enable`; T4 `gra` `r_out` `pc_enable`.
- in (10110): T3 `inport_out` `gra` `r_in`. out (10111): T3 `gra` `r_out` `outport_enable`.
- mfhi (11000): T3 `hi_out` `gra` `r_in`. mflo (11001): T3 `lo_out` `gra` `r_in`.
- nop (11010) and every undefined opcode: T3 with no strobes.
- halt (11011): enter HALT. HALT outputs no strobes, `run`=0, and is left only by `clr`.
- `instr_done`=1 in the final step of each instruction. The next state after that step is T0.
- `instr_count` increments on the edge leaving a final step and saturates at all-ones. halt counts once on entry to HALT.
- Cycles per instruction, including the 3 fetch states: ldi 6; ld and st 8; register and immediate ALU 6; mul/div 7; neg/not 5; branch 7; jr 4; jal 5; in/out/mfhi/mflo/nop 4.

Optional Feature:
- Macro: `CU_SINGLE_STEP_EN`.
- When defined, adds input port `step` (1 bit). After each final step the FSM enters PAUSE instead of T0. PAUSE drives no strobes, keeps `run`=1, and moves to T0 on the first clock with `step`=1. `clr` exits PAUSE to T0.
- When not defined, there is no `step` port and no PAUSE state; the final step goes straight to T0.

Test Plan:
- ldi R2,0x78 (ir=0x09000078) after reset → T0–T5 in 6 clocks; T5 asserts exactly `zlo_out` `gra` `r_in`; `instr_done` pulses once; `instr_count`=1.
- st 0x87,R1 (ir=0x10800087) → 8 clocks; `ram_write` high only in T7; `mar_enable` in T0 and T5 only.
- add R3,R4,R5 (ir=0x19A28000) → T4 asserts `grc` `r_out` `z_enable`; the next fetch begins on clock 7.
- Branch (ir=0x98000000) run twice, once with `con_out`=0 and once with 1 → BR3 `pc_enable` is 0 then 1; both take 7 clocks.
- halt (ir=0xD8000000) → `run`=0 from the edge after T2, no strobes for 20 clocks; `clr` pulse → T0, `run`=1, `instr_count`=0.
- `clr` asserted during st T6 → zero strobes that cycle, no `ram_write`; the next cycle is T0.

Source files
------------

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the Mini SRC datapath.
// Fetches, decodes ir[IR_WIDTH-1 -: 5] and steps through the T-step sequence for that opcode,
// driving every datapath control strobe. Enters HALT on halt and stays there until clr.
// Optional: define CU_SINGLE_STEP_EN to add a `step` input and a PAUSE state after each
// instruction.
module control_unit #(
  parameter int unsigned IR_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [IR_WIDTH-1:0]  ir,
  input  logic                 con_out,
`ifdef CU_SINGLE_STEP_EN
  input  logic                 step,
`endif
  output logic                 pc_out,
  output logic                 zlo_out,
  output logic                 zhi_out,
  output logic                 hi_out,
  output logic                 lo_out,
  output logic                 mdr_out,
  output logic                 inport_out,
  output logic                 c_sign_extended_out,
  output logic                 ba_out,
  output logic                 mar_enable,
  output logic                 z_enable,
  output logic                 pc_enable,
  output logic                 mdr_enable,
  output logic                 ir_enable,
  output logic                 y_enable,
  output logic                 lo_enable,
  output logic                 hi_enable,
  output logic                 r15_enable,
  output logic                 outport_enable,
  output logic                 inport_enable,
  output logic                 con_enable,
  output logic                 read,
  output logic                 ram_write,
  output logic                 pc_increment,
  output logic                 gra,
  output logic                 grb,
  output logic                 grc,
  output logic                 r_in,
  output logic                 r_out,
  output logic                 run,
  output logic                 instr_done,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7,
    StBr0, StBr1, StBr2, StBr3,
    StHalt
`ifdef CU_SINGLE_STEP_EN
    , StPause
`endif
  } state_e;

  // Instruction class captured at the end of fetch; selects the execute-step pattern.
  typedef enum logic [3:0] {
    ClsLd, ClsLdi, ClsSt, ClsAlu, ClsImm, ClsMulDiv, ClsNeg, ClsBr,
    ClsJr, ClsJal, ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsNop, ClsHalt
  } cls_e;

  state_e     state_q;
  cls_e       cls_q;
  cls_e       dec_cls;
  logic [4:0] opcode;
  logic       last_step;
  logic       count_event;
  logic       unused_ir_low;

  assign opcode        = ir[IR_WIDTH-1 -: 5];
  assign unused_ir_low = ^ir[IR_WIDTH-6:0];

  // Opcode to instruction class; undefined opcodes behave as nop.
  always_comb begin
    dec_cls = ClsNop;
    if (opcode == 5'd0)       dec_cls = ClsLd;
    else if (opcode == 5'd1)  dec_cls = ClsLdi;
    else if (opcode == 5'd2)  dec_cls = ClsSt;
    else if (opcode <= 5'd11) dec_cls = ClsAlu;
    else if (opcode <= 5'd14) dec_cls = ClsImm;
    else if (opcode <= 5'd16) dec_cls = ClsMulDiv;
    else if (opcode <= 5'd18) dec_cls = ClsNeg;
    else if (opcode == 5'd19) dec_cls = ClsBr;
    else if (opcode == 5'd20) dec_cls = ClsJr;
    else if (opcode == 5'd21) dec_cls = ClsJal;
    else if (opcode == 5'd22) dec_cls = ClsIn;
    else if (opcode == 5'd23) dec_cls = ClsOut;
    else if (opcode == 5'd24) dec_cls = ClsMfhi;
    else if (opcode == 5'd25) dec_cls = ClsMflo;
    else if (opcode == 5'd27) dec_cls = ClsHalt;
  end

  // Flags the final T-step of the current instruction.
  always_comb begin
    last_step = 1'b0;
    case (state_q)
      StT3:    last_step = cls_q inside {ClsJr, ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsNop};
      StT4:    last_step = cls_q inside {ClsNeg, ClsJal};
      StT5:    last_step = cls_q inside {ClsLdi, ClsAlu, ClsImm};
      StT6:    last_step = (cls_q == ClsMulDiv);
      StT7:    last_step = 1'b1;
      StBr3:   last_step = 1'b1;
      default: last_step = 1'b0;
    endcase
  end

  // halt retires on entry to HALT rather than in a final step.
  assign count_event = last_step || (state_q == StT2 && dec_cls == ClsHalt);

  // Sequencer: state, captured class, run flag and saturating retire counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StT0;
      cls_q       <= ClsNop;
      run         <= 1'b1;
      instr_count <= '0;
    end else begin
      if (count_event && !(&instr_count)) begin
        instr_count <= instr_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (last_step) begin
`ifdef CU_SINGLE_STEP_EN
        state_q <= StPause;
`else
        state_q <= StT0;
`endif
      end else begin
        case (state_q)
          StT0:  state_q <= StT1;
          StT1:  state_q <= StT2;
          StT2: begin
            cls_q <= dec_cls;
            if (dec_cls == ClsHalt) begin
              state_q <= StHalt;
              run     <= 1'b0;
            end else if (dec_cls == ClsBr) begin
              state_q <= StBr0;
            end else begin
              state_q <= StT3;
            end
          end
          StT3:  state_q <= StT4;
          StT4:  state_q <= StT5;
          StT5:  state_q <= StT6;
          StT6:  state_q <= StT7;
          StBr0: state_q <= StBr1;
          StBr1: state_q <= StBr2;
          StBr2: state_q <= StBr3;
`ifdef CU_SINGLE_STEP_EN
          StPause: if (step) state_q <= StT0;
`endif
          default: state_q <= state_q;
        endcase
      end
    end
  end

  // Strobe decode from state; clr masks everything so a mid-instruction reset writes nothing.
  always_comb begin
    pc_out = 1'b0; zlo_out = 1'b0; zhi_out = 1'b0; hi_out = 1'b0; lo_out = 1'b0;
    mdr_out = 1'b0; inport_out = 1'b0; c_sign_extended_out = 1'b0; ba_out = 1'b0;
    mar_enable = 1'b0; z_enable = 1'b0; pc_enable = 1'b0; mdr_enable = 1'b0;
    ir_enable = 1'b0; y_enable = 1'b0; lo_enable = 1'b0; hi_enable = 1'b0;
    r15_enable = 1'b0; outport_enable = 1'b0; inport_enable = 1'b0; con_enable = 1'b0;
    read = 1'b0; ram_write = 1'b0; pc_increment = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0;
    instr_done = 1'b0;
    if (!clr) begin
      instr_done = last_step;
      case (state_q)
        StT0: begin pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1; z_enable = 1'b1; end
        StT1: begin zlo_out = 1'b1; pc_enable = 1'b1; read = 1'b1; mdr_enable = 1'b1; end
        StT2: begin mdr_out = 1'b1; ir_enable = 1'b1; end
        StT3: begin
          case (cls_q)
            ClsLd, ClsLdi, ClsSt: begin grb = 1'b1; ba_out = 1'b1; y_enable = 1'b1; end
            ClsAlu, ClsImm:       begin grb = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
            ClsMulDiv:            begin gra = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
            ClsNeg:               begin grb = 1'b1; r_out = 1'b1; z_enable = 1'b1; end
            ClsJr:                begin gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1; end
            ClsJal:               begin pc_out = 1'b1; r15_enable = 1'b1; end
            ClsIn:                begin inport_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            ClsOut:               begin gra = 1'b1; r_out = 1'b1; outport_enable = 1'b1; end
            ClsMfhi:              begin hi_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            ClsMflo:              begin lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            default: ;
          endcase
        end
        StT4: begin
          case (cls_q)
            ClsLd, ClsLdi, ClsSt, ClsImm: begin c_sign_extended_out = 1'b1; z_enable = 1'b1; end
            ClsAlu:    begin grc = 1'b1; r_out = 1'b1; z_enable = 1'b1; end
            ClsMulDiv: begin grb = 1'b1; r_out = 1'b1; z_enable = 1'b1; end
            ClsNeg:    begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            ClsJal:    begin gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1; end
            default: ;
          endcase
        end
        StT5: begin
          case (cls_q)
            ClsLd, ClsSt:          begin zlo_out = 1'b1; mar_enable = 1'b1; end
            ClsLdi, ClsAlu, ClsImm: begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            ClsMulDiv:             begin zlo_out = 1'b1; lo_enable = 1'b1; end
            default: ;
          endcase
        end
        StT6: begin
          case (cls_q)
            ClsLd:     begin read = 1'b1; mdr_enable = 1'b1; end
            ClsSt:     begin gra = 1'b1; r_out = 1'b1; mdr_enable = 1'b1; end
            ClsMulDiv: begin zhi_out = 1'b1; hi_enable = 1'b1; end
            default: ;
          endcase
        end
        StT7: begin
          if (cls_q == ClsLd) begin
            mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
          end else begin
            ram_write = 1'b1;
          end
        end
        StBr0: begin gra = 1'b1; r_out = 1'b1; con_enable = 1'b1; end
        StBr1: begin pc_out = 1'b1; y_enable = 1'b1; end
        StBr2: begin c_sign_extended_out = 1'b1; z_enable = 1'b1; end
        StBr3: begin zlo_out = 1'b1; pc_enable = con_out; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed test-plan scenarios plus random
// instruction streams compared per cycle against a step-list model of the opcode table.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        con_out;
  logic pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out;
  logic ba_out, mar_enable, z_enable, pc_enable, mdr_enable, ir_enable, y_enable, lo_enable;
  logic hi_enable, r15_enable, outport_enable, inport_enable, con_enable, read, ram_write;
  logic pc_increment, gra, grb, grc, r_in, r_out, run, instr_done;
  logic [15:0] instr_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int model_count  = 0;
  logic [28:0] exp_q[$];

  always #5 clk = ~clk;

  control_unit #(.IR_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .clr(clr), .ir(ir), .con_out(con_out),
    .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .hi_out(hi_out), .lo_out(lo_out),
    .mdr_out(mdr_out), .inport_out(inport_out), .c_sign_extended_out(c_sign_extended_out),
    .ba_out(ba_out), .mar_enable(mar_enable), .z_enable(z_enable), .pc_enable(pc_enable),
    .mdr_enable(mdr_enable), .ir_enable(ir_enable), .y_enable(y_enable),
    .lo_enable(lo_enable), .hi_enable(hi_enable), .r15_enable(r15_enable),
    .outport_enable(outport_enable), .inport_enable(inport_enable), .con_enable(con_enable),
    .read(read), .ram_write(ram_write), .pc_increment(pc_increment), .gra(gra), .grb(grb),
    .grc(grc), .r_in(r_in), .r_out(r_out), .run(run), .instr_done(instr_done),
    .instr_count(instr_count)
  );

  logic [28:0] strobes;
  assign strobes = {r_out, r_in, grc, grb, gra, pc_increment, ram_write, read, con_enable,
                    inport_enable, outport_enable, r15_enable, hi_enable, lo_enable, y_enable,
                    ir_enable, mdr_enable, pc_enable, z_enable, mar_enable, ba_out,
                    c_sign_extended_out, inport_out, mdr_out, lo_out, hi_out, zhi_out,
                    zlo_out, pc_out};

  localparam logic [28:0] M_PC_OUT  = 29'h1 << 0,  M_ZLO_OUT = 29'h1 << 1;
  localparam logic [28:0] M_ZHI_OUT = 29'h1 << 2,  M_HI_OUT  = 29'h1 << 3;
  localparam logic [28:0] M_LO_OUT  = 29'h1 << 4,  M_MDR_OUT = 29'h1 << 5;
  localparam logic [28:0] M_INP_OUT = 29'h1 << 6,  M_CSE_OUT = 29'h1 << 7;
  localparam logic [28:0] M_BA_OUT  = 29'h1 << 8,  M_MAR_EN  = 29'h1 << 9;
  localparam logic [28:0] M_Z_EN    = 29'h1 << 10, M_PC_EN   = 29'h1 << 11;
  localparam logic [28:0] M_MDR_EN  = 29'h1 << 12, M_IR_EN   = 29'h1 << 13;
  localparam logic [28:0] M_Y_EN    = 29'h1 << 14, M_LO_EN   = 29'h1 << 15;
  localparam logic [28:0] M_HI_EN   = 29'h1 << 16, M_R15_EN  = 29'h1 << 17;
  localparam logic [28:0] M_OUTP_EN = 29'h1 << 18, M_CON_EN  = 29'h1 << 20;
  localparam logic [28:0] M_READ    = 29'h1 << 21, M_RAM_WR  = 29'h1 << 22;
  localparam logic [28:0] M_PC_INC  = 29'h1 << 23, M_GRA     = 29'h1 << 24;
  localparam logic [28:0] M_GRB     = 29'h1 << 25, M_GRC     = 29'h1 << 26;
  localparam logic [28:0] M_R_IN    = 29'h1 << 27, M_R_OUT   = 29'h1 << 28;
  localparam logic [28:0] M_F0      = M_PC_OUT | M_MAR_EN | M_PC_INC | M_Z_EN;

  // Reference: list of per-cycle strobe sets for one instruction, straight from the opcode table.
  task automatic build_seq(input logic [4:0] op, input logic con);
    exp_q.delete();
    exp_q.push_back(M_F0);
    exp_q.push_back(M_ZLO_OUT | M_PC_EN | M_READ | M_MDR_EN);
    exp_q.push_back(M_MDR_OUT | M_IR_EN);
    if (op <= 5'd2) begin
      exp_q.push_back(M_GRB | M_BA_OUT | M_Y_EN);
      exp_q.push_back(M_CSE_OUT | M_Z_EN);
      if (op == 5'd1) exp_q.push_back(M_ZLO_OUT | M_GRA | M_R_IN);
      else begin
        exp_q.push_back(M_ZLO_OUT | M_MAR_EN);
        if (op == 5'd0) begin
          exp_q.push_back(M_READ | M_MDR_EN);
          exp_q.push_back(M_MDR_OUT | M_GRA | M_R_IN);
        end else begin
          exp_q.push_back(M_GRA | M_R_OUT | M_MDR_EN);
          exp_q.push_back(M_RAM_WR);
        end
      end
    end else if (op <= 5'd14) begin
      exp_q.push_back(M_GRB | M_R_OUT | M_Y_EN);
      exp_q.push_back((op <= 5'd11) ? (M_GRC | M_R_OUT | M_Z_EN) : (M_CSE_OUT | M_Z_EN));
      exp_q.push_back(M_ZLO_OUT | M_GRA | M_R_IN);
    end else if (op <= 5'd16) begin
      exp_q.push_back(M_GRA | M_R_OUT | M_Y_EN);
      exp_q.push_back(M_GRB | M_R_OUT | M_Z_EN);
      exp_q.push_back(M_ZLO_OUT | M_LO_EN);
      exp_q.push_back(M_ZHI_OUT | M_HI_EN);
    end else if (op <= 5'd18) begin
      exp_q.push_back(M_GRB | M_R_OUT | M_Z_EN);
      exp_q.push_back(M_ZLO_OUT | M_GRA | M_R_IN);
    end else if (op == 5'd19) begin
      exp_q.push_back(M_GRA | M_R_OUT | M_CON_EN);
      exp_q.push_back(M_PC_OUT | M_Y_EN);
      exp_q.push_back(M_CSE_OUT | M_Z_EN);
      exp_q.push_back(con ? (M_ZLO_OUT | M_PC_EN) : M_ZLO_OUT);
    end else if (op == 5'd20) exp_q.push_back(M_GRA | M_R_OUT | M_PC_EN);
    else if (op == 5'd21) begin
      exp_q.push_back(M_PC_OUT | M_R15_EN);
      exp_q.push_back(M_GRA | M_R_OUT | M_PC_EN);
    end else if (op == 5'd22) exp_q.push_back(M_INP_OUT | M_GRA | M_R_IN);
    else if (op == 5'd23) exp_q.push_back(M_GRA | M_R_OUT | M_OUTP_EN);
    else if (op == 5'd24) exp_q.push_back(M_HI_OUT | M_GRA | M_R_IN);
    else if (op == 5'd25) exp_q.push_back(M_LO_OUT | M_GRA | M_R_IN);
    else if (op != 5'd27) exp_q.push_back('0);
  endtask

  // Runs one non-halt instruction from T0, checking every cycle, then the retire count.
  task automatic run_instr(input logic [31:0] instr, input logic con, input string name);
    int n;
    ir      = instr;
    con_out = con;
    build_seq(instr[31:27], con);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      #1;
      tests_run++;
      if (strobes !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL %s step %0d strobes: got %h expected %h", name, i, strobes, exp_q[i]);
      end
      tests_run++;
      if (instr_done !== (i == n - 1) || run !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s step %0d done/run: got %b/%b expected %b/1", name, i, instr_done,
                 run, (i == n - 1));
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (model_count < 65535) model_count++;
    #1;
    tests_run++;
    if (instr_count !== 16'(model_count) || strobes !== M_F0) begin
      tests_failed++;
      $display("FAIL %s retire: count %0d strobes %h expected count %0d strobes %h", name,
               instr_count, strobes, model_count, M_F0);
    end
  endtask

  task automatic test_reset;
    clr = 1'b1; ir = '0; con_out = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    tests_run++;
    if (strobes !== '0 || instr_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mask: got %h/%b expected 0/0", strobes, instr_done);
    end
    clr = 1'b0; #1;
    model_count = 0;
    tests_run++;
    if (run !== 1'b1 || instr_count !== 16'd0 || strobes !== M_F0) begin
      tests_failed++;
      $display("FAIL reset_state: run %b count %0d strobes %h expected 1 0 %h", run,
               instr_count, strobes, M_F0);
    end
  endtask

  task automatic test_ldi;    run_instr(32'h0900_0078, 1'b0, "ldi");   endtask
  task automatic test_st;     run_instr(32'h1080_0087, 1'b0, "st");    endtask
  task automatic test_add;    run_instr(32'h19A2_8000, 1'b0, "add");   endtask

  task automatic test_branch;
    run_instr(32'h9800_0000, 1'b0, "br_nt");
    run_instr(32'h9800_0000, 1'b1, "br_t");
  endtask

  task automatic test_random;
    for (int k = 0; k < 60; k++) begin
      int unsigned r;
      logic [4:0]  op;
      r  = $urandom_range(0, 30);
      op = (r >= 27) ? 5'(r + 1) : 5'(r);
      run_instr({op, 27'($urandom)}, 1'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back;
    run_instr(32'h7800_0000, 1'b0, "mul");
    run_instr(32'hA800_0000, 1'b0, "jal");
    run_instr(32'h8800_0000, 1'b0, "neg");
    run_instr(32'h0000_0010, 1'b0, "ld");
  endtask

  task automatic test_clr_mid;
    ir = 32'h1080_0087; con_out = 1'b0;
    build_seq(5'd2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      #1;
      tests_run++;
      if (strobes !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL clr_mid step %0d: got %h expected %h", i, strobes, exp_q[i]);
      end
      @(posedge clk); @(negedge clk);
    end
    clr = 1'b1; #1;
    tests_run++;
    if (strobes !== '0 || ram_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_mid_mask: got %h expected 0", strobes);
    end
    @(posedge clk); @(negedge clk);
    clr = 1'b0; #1;
    model_count = 0;
    tests_run++;
    if (strobes !== M_F0 || instr_count !== 16'd0 || run !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_mid_restart: strobes %h count %0d run %b expected %h 0 1", strobes,
               instr_count, run, M_F0);
    end
  endtask

  task automatic test_halt;
    ir = 32'hD800_0000; con_out = 1'b0;
    build_seq(5'd27, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (strobes !== exp_q[i] || run !== 1'b1) begin
        tests_failed++;
        $display("FAIL halt_fetch step %0d: got %h run %b expected %h run 1", i, strobes, run,
                 exp_q[i]);
      end
      @(posedge clk); @(negedge clk);
    end
    if (model_count < 65535) model_count++;
    for (int i = 0; i < 20; i++) begin
      #1;
      tests_run++;
      if (strobes !== '0 || run !== 1'b0 || instr_done !== 1'b0 ||
          instr_count !== 16'(model_count)) begin
        tests_failed++;
        $display("FAIL halt_idle cycle %0d: strobes %h run %b done %b count %0d expected 0 0 0 %0d",
                 i, strobes, run, instr_done, instr_count, model_count);
      end
      @(posedge clk); @(negedge clk);
    end
    clr = 1'b1;
    @(posedge clk); @(negedge clk);
    clr = 1'b0; #1;
    model_count = 0;
    tests_run++;
    if (strobes !== M_F0 || run !== 1'b1 || instr_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL halt_exit: strobes %h run %b count %0d expected %h 1 0", strobes, run,
               instr_count, M_F0);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_st();
    test_add();
    test_branch();
    test_back_to_back();
    test_random();
    test_clr_mid();
    test_ldi();
    test_halt();
    test_add();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
